// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl
//   Avalon-MM fade controller producing the 8-bit duty value for PWM8.
//   The CPU writes TARGET and STEP_DIV; the block ramps `value` toward
//   TARGET by +/-1 every STEP_DIV+1 clocks and flags completion with a
//   sticky done bit and a level interrupt.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   address    0 TARGET, 1 STEP_DIV, 2 CTRL{irq_en,en}, 3 STATUS
//   write      single-cycle write strobe
//   writedata  write data
//   read       read strobe
//   readdata   registered read data, latency 1, holds when read=0
//   value      current duty value
//   irq        done & irq_en
module pwm_fade_ctrl #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic [7:0]  value,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN
  } state_t;

  state_t                state;
  logic [7:0]            target;
  logic [PRESCALE_W-1:0] step_div;
  logic [PRESCALE_W-1:0] prescaler;
  logic                  en;
  logic                  irq_en;
  logic                  done;

  logic                  busy;
  logic                  tick;
  logic                  target_wr;
  logic [7:0]            next_value;
  logic                  unused_wd;

  always_comb begin
    busy       = (state != IDLE);
    tick       = busy && en && (prescaler == step_div);
    target_wr  = write && (address == 2'd0);
    next_value = (state == DOWN) ? (value - 8'd1) : (value + 8'd1);
  end

  assign irq       = done & irq_en;
  assign unused_wd = ^{writedata[31:10], writedata[8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      target    <= '0;
      step_div  <= '0;
      prescaler <= '0;
      en        <= 1'b1;
      irq_en    <= 1'b0;
      done      <= 1'b0;
      value     <= '0;
      readdata  <= '0;
    end else begin
      if (write) begin
        case (address)
          2'd1:    step_div <= writedata[PRESCALE_W-1:0];
          2'd2: begin
            en     <= writedata[0];
            irq_en <= writedata[1];
          end
          2'd3:    if (writedata[9]) done <= 1'b0;
          default: ;
        endcase
      end

      // A TARGET write overrides any tick on the same edge; the done-set
      // assignments below come after the clear so a coincident set wins.
      if (target_wr) begin
        target    <= writedata[7:0];
        prescaler <= '0;
        if (writedata[7:0] > value) begin
          state <= UP;
        end else if (writedata[7:0] < value) begin
          state <= DOWN;
        end else begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end else if (busy && en) begin
        if (tick) begin
          prescaler <= '0;
          value     <= next_value;
          if (next_value == target) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end else begin
          prescaler <= prescaler + PRESCALE_W'(1);
        end
      end

      if (read) begin
        case (address)
          2'd0:    readdata <= {24'd0, target};
          2'd1:    readdata <= 32'(step_div);
          2'd2:    readdata <= {30'd0, irq_en, en};
          default: readdata <= {22'd0, done, busy, value};
        endcase
      end
    end
  end

endmodule
